route_compute_pipelined: RTL

Registered, parametrised per-input-port route computation unit for the mesh wormhole router. It decodes head flits, computes the dimension-ordered output port (XY or YX, chosen at build time) and holds that port for the packet's body and tail flits. It also tracks packet framing per input and flags malformed or unroutable traffic. It sits between the input buffers and the switch allocator, and adds exactly one pipeline stage.

---
 rtl/route_compute_pipelined_if.sv | 31 +++
 rtl/route_compute_pipelined.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/route_compute_pipelined_if.sv
// Flit-side bus of the per-input route computation unit.
//   flit_in    : one flit per input port, port i at [i*FLIT_W +: FLIT_W]
//   flit_valid : per-port flit qualifier
//   op_port    : 3-bit output port per input (N=0,E=1,S=2,W=3,L=4)
//   op_valid   : op_port applies to the flit accepted on the previous cycle
//   pkt_active : port is inside a routed packet
//   route_err  : pulse, head destination outside the mesh
//   proto_err  : pulse, packet framing violation
// master drives flits (buffers side), slave is the route unit.
interface route_compute_pipelined_if #(
  parameter int NUM_PORTS = 5,
  parameter int FLIT_W    = 8
);
  logic [NUM_PORTS*FLIT_W-1:0] flit_in;
  logic [NUM_PORTS-1:0]        flit_valid;
  logic [NUM_PORTS*3-1:0]      op_port;
  logic [NUM_PORTS-1:0]        op_valid;
  logic [NUM_PORTS-1:0]        pkt_active;
  logic [NUM_PORTS-1:0]        route_err;
  logic [NUM_PORTS-1:0]        proto_err;

  modport master (
    output flit_in, flit_valid,
    input  op_port, op_valid, pkt_active, route_err, proto_err
  );

  modport slave (
    input  flit_in, flit_valid,
    output op_port, op_valid, pkt_active, route_err, proto_err
  );
endinterface

// File: rtl/route_compute_pipelined.sv
// Per-input-port dimension-ordered route computation with one register stage.
// Each input has an independent IDLE/ACTIVE/DROP framing FSM: head flits pick
// the output port (XY or YX order), body/tail flits reuse it, unroutable
// packets are dropped until their tail.
//   clk : clock, rising edge
//   rst : synchronous, active-low reset
//   bus : route_compute_pipelined_if slave (flits in, route results out)
module route_compute_pipelined #(
  parameter int NUM_PORTS = 5,
  parameter int FLIT_W    = 8,
  parameter int COORD_W   = 3,
  parameter int MESH_X    = 4,
  parameter int MESH_Y    = 4,
  parameter int ROUTER_ID = 0,
  parameter int MODE_YX   = 0
) (
  input logic                   clk,
  input logic                   rst,
  route_compute_pipelined_if.slave bus
);

  localparam logic [1:0] TYPE_HEAD = 2'b00;
  localparam logic [1:0] TYPE_BODY = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;

  localparam logic [2:0] DIR_NORTH = 3'd0;
  localparam logic [2:0] DIR_EAST  = 3'd1;
  localparam logic [2:0] DIR_SOUTH = 3'd2;
  localparam logic [2:0] DIR_WEST  = 3'd3;
  localparam logic [2:0] DIR_LOCAL = 3'd4;

  localparam logic [COORD_W-1:0] MY_X   = COORD_W'(ROUTER_ID % MESH_X);
  localparam logic [COORD_W-1:0] MY_Y   = COORD_W'(ROUTER_ID / MESH_X);
  // One extra bit so a mesh dimension of 2**COORD_W still compares correctly.
  localparam logic [COORD_W:0]   LIM_X  = (COORD_W+1)'(MESH_X);
  localparam logic [COORD_W:0]   LIM_Y  = (COORD_W+1)'(MESH_Y);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_t;

  state_t                 state_q [NUM_PORTS];
  state_t                 state_d [NUM_PORTS];
  logic [NUM_PORTS*3-1:0] port_q, port_d;
  logic [NUM_PORTS-1:0]   valid_q, valid_d;
  logic [NUM_PORTS-1:0]   active_q;
  logic [NUM_PORTS-1:0]   rerr_q, rerr_d;
  logic [NUM_PORTS-1:0]   perr_q, perr_d;
  logic [FLIT_W-1:0]      flit [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_slice
    assign flit[g] = bus.flit_in[g*FLIT_W +: FLIT_W];
  end

  function automatic logic [2:0] route_of(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    logic [2:0] xdir;
    logic [2:0] ydir;
    xdir = (dx > MY_X) ? DIR_EAST  : DIR_WEST;
    ydir = (dy > MY_Y) ? DIR_NORTH : DIR_SOUTH;
    if (MODE_YX == 0) begin
      if (dx != MY_X)      route_of = xdir;
      else if (dy != MY_Y) route_of = ydir;
      else                 route_of = DIR_LOCAL;
    end else begin
      if (dy != MY_Y)      route_of = ydir;
      else if (dx != MY_X) route_of = xdir;
      else                 route_of = DIR_LOCAL;
    end
  endfunction

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    valid_d = '0;
    rerr_d  = '0;
    perr_d  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (bus.flit_valid[i]) begin
        if (flit[i][1:0] == TYPE_HEAD) begin
          // A head restarts the port from any state; only ACTIVE flags it.
          if (state_q[i] == ACTIVE) perr_d[i] = 1'b1;
          if ({1'b0, flit[i][COORD_W+1:2]} < LIM_X &&
              {1'b0, flit[i][2*COORD_W+1:COORD_W+2]} < LIM_Y) begin
            port_d[i*3 +: 3] = route_of(flit[i][COORD_W+1:2],
                                        flit[i][2*COORD_W+1:COORD_W+2]);
            valid_d[i] = 1'b1;
            state_d[i] = ACTIVE;
          end else begin
            rerr_d[i]  = 1'b1;
            state_d[i] = DROP;
          end
        end else begin
          case (state_q[i])
            ACTIVE: begin
              if (flit[i][1:0] == TYPE_BODY) begin
                valid_d[i] = 1'b1;
              end else if (flit[i][1:0] == TYPE_TAIL) begin
                valid_d[i] = 1'b1;
                state_d[i] = IDLE;
              end else begin
                perr_d[i] = 1'b1;
              end
            end
            DROP: begin
              if (flit[i][1:0] == TYPE_TAIL)      state_d[i] = IDLE;
              else if (flit[i][1:0] != TYPE_BODY) perr_d[i]  = 1'b1;
            end
            default: perr_d[i] = 1'b1;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) state_q[i] <= IDLE;
      port_q   <= '0;
      valid_q  <= '0;
      active_q <= '0;
      rerr_q   <= '0;
      perr_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        state_q[i]  <= state_d[i];
        active_q[i] <= (state_d[i] == ACTIVE);
      end
      port_q  <= port_d;
      valid_q <= valid_d;
      rerr_q  <= rerr_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.op_port    = port_q;
  assign bus.op_valid   = valid_q;
  assign bus.pkt_active = active_q;
  assign bus.route_err  = rerr_q;
  assign bus.proto_err  = perr_q;

endmodule
